// File: rtl/booth_seq_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_mul_ctrl
// Description : Sequential radix-2 Booth multiplier controller. One shared
//               add/sub-and-shift step per cycle, N+1 steps per product.
//               Optional BOOTH_EARLY_TERM_EN: finish as soon as the remaining
//               multiplier bits cannot trigger another add/sub.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_mul_ctrl #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N:0]       a,
    input  logic [N:0]       b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*N+1:0]   product
);

    localparam int              c_cw       = $clog2(N + 2);
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(N + 1);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [N+1:0]    r_acc;
    logic [N+1:0]    r_m;
    logic [N:0]      r_q;
    logic            r_q1;
    logic [c_cw-1:0] r_cnt;

    logic            w_accept;
    logic            w_last;
    logic            w_early;
    logic [N+1:0]    w_addsub;
    logic [N+1:0]    w_acc_sh;
    logic [N:0]      w_q_sh;
    logic            w_q1_sh;

    assign w_accept = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_last   = (r_state == c_st_run) && (w_early || (r_cnt == c_cnt_one));

    // Booth recoding of the current bit pair; ACC is one bit wider than the
    // operands so that subtracting the most negative multiplicand cannot wrap.
    always_comb begin
        w_addsub = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_addsub = r_acc + r_m;
            2'b10:   w_addsub = r_acc - r_m;
            default: w_addsub = r_acc;
        endcase
    end

    assign w_acc_sh = {w_addsub[N+1], w_addsub[N+1:1]};
    assign w_q_sh   = {w_addsub[0], r_q[N:1]};
    assign w_q1_sh  = r_q[0];

`ifdef BOOTH_EARLY_TERM_EN
    logic [N:0]     w_mask;
    logic [N:0]     w_qlow;
    logic [2*N+3:0] w_et_vec;

    // Once the unconsumed multiplier bits are uniform, every later pair is
    // 00/11. The pending step's add/sub is folded in, then one wide shift.
    assign w_mask   = ~({(N+1){1'b1}} << r_cnt);
    assign w_qlow   = r_q & w_mask;
    assign w_early  = (w_qlow == '0) || (w_qlow == w_mask);
    assign w_et_vec = $signed({w_addsub, r_q, r_q1}) >>> r_cnt;
`else
    assign w_early  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= '0;
            product <= '0;
        end else if (w_accept) begin
            r_acc   <= '0;
            r_m     <= {a[N], a};
            r_q     <= b;
            r_q1    <= 1'b0;
            r_cnt   <= c_cnt_init;
        end else if (r_state == c_st_run) begin
`ifdef BOOTH_EARLY_TERM_EN
            if (w_early) begin
                r_acc   <= w_et_vec[2*N+3:N+2];
                r_q     <= w_et_vec[N+1:1];
                r_q1    <= w_et_vec[0];
                r_cnt   <= '0;
                product <= w_et_vec[2*N+2:1];
            end else
`endif
            begin
                r_acc <= w_acc_sh;
                r_q   <= w_q_sh;
                r_q1  <= w_q1_sh;
                r_cnt <= r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    product <= {w_acc_sh[N:0], w_q_sh};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start)  w_state_nxt = c_st_run;
            c_st_run:  if (w_last) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = start ? c_st_run : c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            c_st_idle: ready = 1'b1;
            c_st_run:  busy  = 1'b1;
            c_st_done: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default:   ready = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_mul_ctrl
// Description : Directed self-checking bench for booth_seq_mul_ctrl (N=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_mul_ctrl;

    localparam int N = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N:0]    a;
    logic [N:0]    b;
    logic          ready;
    logic          busy;
    logic          done;
    logic [2*N+1:0] product;

    int checks = 0;
    int errors = 0;

    booth_seq_mul_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and wait (bounded) for done; lat = edges after accept.
    task automatic run_op(input logic [N:0] ta, input logic [N:0] tb, output int lat);
        a     = ta;
        b     = tb;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (product !== 18'h0) begin errors++; $display("FAIL reset_product: got %h expected 0", product); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        int busy_bad;
        a     = 9'd7;
        b     = 9'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_run: got %b expected 0", ready); end
        lat = 0;
        busy_bad = 0;
        while (!done && lat < 40) begin
            if (busy !== 1'b1 || ready !== 1'b0) busy_bad++;
            tick();
            lat++;
        end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL basic_busy_run: got %0d bad cycles expected 0", busy_bad); end
`ifdef BOOTH_EARLY_TERM_EN
        checks++; if (lat < 1 || lat > 9) begin errors++; $display("FAIL basic_latency: got %0d expected 1..9", lat); end
`else
        checks++; if (lat != 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
`endif
        checks++; if (product !== 18'h00015) begin errors++; $display("FAIL basic_product: got %h expected 00015", product); end
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_flags: got ready=%b busy=%b expected ready=1 busy=0", ready, busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done); end
        checks++; if (product !== 18'h00015) begin errors++; $display("FAIL basic_product_hold: got %h expected 00015", product); end
    endtask

    task automatic test_signed();
        int lat;
        run_op(9'h1FB, 9'd6, lat);  // -5 * 6
        checks++; if (!done) begin errors++; $display("FAIL mixed_done: got timeout after %0d cycles expected done", lat); end
        checks++; if (product !== 18'h3FFE2) begin errors++; $display("FAIL mixed_product: got %h expected 3ffe2", product); end
        tick();
        run_op(9'h100, 9'h100, lat);  // -256 * -256
        checks++; if (!done) begin errors++; $display("FAIL corner_done: got timeout after %0d cycles expected done", lat); end
        checks++; if (product !== 18'h10000) begin errors++; $display("FAIL corner_product: got %h expected 10000", product); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        // b=170 alternates bits, so no early finish is possible in either build
        a     = 9'd3;
        b     = 9'd170;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        repeat (3) begin tick(); lat++; end
        a     = 9'd1;
        b     = 9'd1;
        start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 9", lat); end
        checks++; if (product !== 18'h001FE) begin errors++; $display("FAIL b2b_first_product: got %h expected 001fe", product); end
        a     = 9'd2;
        b     = 9'h1FD;  // -3
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done); end
        checks++; if (product !== 18'h001FE) begin errors++; $display("FAIL b2b_hold: got %h expected 001fe", product); end
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
`ifdef BOOTH_EARLY_TERM_EN
        checks++; if (lat < 1 || lat > 9) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 1..9", lat); end
`else
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 9", lat); end
`endif
        checks++; if (product !== 18'h3FFFA) begin errors++; $display("FAIL b2b_second_product: got %h expected 3fffa", product); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        a     = 9'd9;
        b     = 9'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got ready=%b busy=%b expected ready=1 busy=0", ready, busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
        checks++; if (product !== 18'h0) begin errors++; $display("FAIL rstmid_product: got %h expected 0", product); end
        tick();
        run_op(9'd9, 9'd9, lat);
        checks++; if (!done) begin errors++; $display("FAIL rstmid_rerun_done: got timeout after %0d cycles expected done", lat); end
        checks++; if (product !== 18'd81) begin errors++; $display("FAIL rstmid_rerun_product: got %h expected 00051", product); end
        tick();
    endtask

    task automatic test_early_term();
        int lat;
        run_op(9'd100, 9'd0, lat);
`ifdef BOOTH_EARLY_TERM_EN
        checks++; if (lat != 1) begin errors++; $display("FAIL et_zero_latency: got %0d expected 1", lat); end
`else
        checks++; if (lat != 9) begin errors++; $display("FAIL et_zero_latency: got %0d expected 9", lat); end
`endif
        checks++; if (product !== 18'h0) begin errors++; $display("FAIL et_zero_product: got %h expected 0", product); end
        tick();
        run_op(9'd5, 9'h1FF, lat);  // 5 * -1
`ifdef BOOTH_EARLY_TERM_EN
        checks++; if (lat != 1) begin errors++; $display("FAIL et_ones_latency: got %0d expected 1", lat); end
`else
        checks++; if (lat != 9) begin errors++; $display("FAIL et_ones_latency: got %0d expected 9", lat); end
`endif
        checks++; if (product !== 18'h3FFFB) begin errors++; $display("FAIL et_ones_product: got %h expected 3fffb", product); end
        tick();
        run_op(9'd3, 9'd2, lat);
`ifdef BOOTH_EARLY_TERM_EN
        checks++; if (lat >= 9) begin errors++; $display("FAIL et_two_latency: got %0d expected below 9", lat); end
`else
        checks++; if (lat != 9) begin errors++; $display("FAIL et_two_latency: got %0d expected 9", lat); end
`endif
        checks++; if (product !== 18'd6) begin errors++; $display("FAIL et_two_product: got %h expected 00006", product); end
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_reset_mid_op();
        test_early_term();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
